// File: rtl/ucsbece154b_mem_pkg.sv
// Types and defaults shared by the instruction cache and the SDRAM line-fill model.
package ucsbece154b_mem_pkg;

    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_WORD_SIZE   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } mem_state_t;

    function automatic int log_block_words(input int block_words);
        return $clog2(block_words);
    endfunction

    localparam int LOG_BLOCK_WORDS = log_block_words(DEF_BLOCK_WORDS);

endpackage

// File: rtl/ucsbece154b_sdram_array.sv
// Backing word array with one registered read port; contents survive reset.
module ucsbece154b_sdram_array #(
    parameter int    WORD_SIZE = 32,
    parameter int    MEM_WORDS = 4096,
    parameter string INIT_FILE = ""
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rd_en,
    input  logic [$clog2(MEM_WORDS)-1:0] rd_addr,
    output logic [WORD_SIZE-1:0]         rd_data
);

    logic [WORD_SIZE-1:0] mem [0:MEM_WORDS-1];

    // Only the output register is reset; the array itself is never cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ucsbece154b_sdram_ctrl.sv
// Line-fill SDRAM model: fixed first-word latency, then a critical-word-first
// wrapping burst of one line, each word tagged with its index in the line.
module ucsbece154b_sdram_ctrl
    import ucsbece154b_mem_pkg::*;
#(
    parameter int    BLOCK_WORDS   = DEF_BLOCK_WORDS,
    parameter int    WORD_SIZE     = DEF_WORD_SIZE,
    parameter int    MEM_WORDS     = 4096,
    parameter int    FIRST_LATENCY = 8,
    parameter string INIT_FILE     = ""
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           memReadRequest,
    input  logic [31:0]                    memReadAddress,
    output logic                           memDataReady,
    output logic [WORD_SIZE-1:0]           memDataIn,
    output logic [$clog2(BLOCK_WORDS)-1:0] memBlockIndex,
    output logic                           busy
);

    // state | meaning
    // IDLE  | waiting for memReadRequest; word address latched on acceptance
    // WAIT  | counting down the first-word latency; request drop aborts
    // BURST | one beat per cycle, request ignored until the line is done

    localparam int LOG_BW  = log_block_words(BLOCK_WORDS);
    localparam int LOG_MEM = $clog2(MEM_WORDS);
    localparam int LAT_W   = $clog2(FIRST_LATENCY + 1);

    mem_state_t          state, state_next;
    logic [LAT_W-1:0]    cnt, cnt_next;
    logic [LOG_BW-1:0]   beat, beat_next;
    logic [LOG_MEM-1:0]  addr_q;
    logic [LOG_BW-1:0]   idx_next;
    logic [LOG_MEM-1:0]  rd_addr;
    logic                rd_en;
    logic                unused_addr;

    assign unused_addr = ^{memReadAddress[31:LOG_MEM+2], memReadAddress[1:0]};

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        beat_next  = beat;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (memReadRequest) begin
                    state_next = WAIT;
                    cnt_next   = LAT_W'(FIRST_LATENCY - 1);
                end
            end
            WAIT: begin
                if (!memReadRequest) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = BURST;
                    beat_next  = '0;
                    rd_en      = 1'b1;
                end else begin
                    cnt_next = cnt - LAT_W'(1);
                end
            end
            BURST: begin
                if (beat == LOG_BW'(BLOCK_WORDS - 1)) begin
                    state_next = IDLE;
                end else begin
                    beat_next = beat + LOG_BW'(1);
                    rd_en     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // The array is addressed with the upcoming beat so its registered output
    // lines up with memDataReady and memBlockIndex.
    assign idx_next = addr_q[LOG_BW-1:0] + beat_next;
    assign rd_addr  = {addr_q[LOG_MEM-1:LOG_BW], idx_next};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            beat          <= '0;
            addr_q        <= '0;
            memDataReady  <= 1'b0;
            memBlockIndex <= '0;
            busy          <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            beat         <= beat_next;
            memDataReady <= rd_en;
            busy         <= (state_next != IDLE);
            if (state == IDLE && memReadRequest)
                addr_q <= memReadAddress[LOG_MEM+1:2];
            if (rd_en)
                memBlockIndex <= idx_next;
        end
    end

    ucsbece154b_sdram_array #(
        .WORD_SIZE (WORD_SIZE),
        .MEM_WORDS (MEM_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (memDataIn)
    );

endmodule

// File: tb/tb_ucsbece154b_sdram_ctrl.sv
// Scoreboard bench: stimulus pushes expected beats/busy windows, a monitor pops and compares.
module tb_ucsbece154b_sdram_ctrl;

    localparam int BW = 4;
    localparam int FL = 8;
    localparam int MW = 4096;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memReadRequest = 1'b0;
    logic [31:0] memReadAddress = '0;
    logic        memDataReady;
    logic [31:0] memDataIn;
    logic [1:0]  memBlockIndex;
    logic        busy;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_mem [MW];
    beat_t       exp_q [$];
    win_t        busy_q [$];

    ucsbece154b_sdram_ctrl #(
        .BLOCK_WORDS   (BW),
        .WORD_SIZE     (32),
        .MEM_WORDS     (MW),
        .FIRST_LATENCY (FL),
        .INIT_FILE     ("")
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .memReadRequest (memReadRequest),
        .memReadAddress (memReadAddress),
        .memDataReady   (memDataReady),
        .memDataIn      (memDataIn),
        .memBlockIndex  (memBlockIndex),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples just after the falling edge, or just after reset assertion.
    initial begin
        beat_t b;
        win_t  w;
        logic  exp_busy, exp_ready;
        forever begin
            @(negedge clk or negedge reset);
            #1;
            if (!reset) begin
                chk("rst_ready", memDataReady, 0);
                chk("rst_index", memBlockIndex, 0);
                chk("rst_data", memDataIn, 0);
                chk("rst_busy", busy, 0);
            end else begin
                while (busy_q.size() > 0 && busy_q[0].hi < cyc) w = busy_q.pop_front();
                exp_busy = (busy_q.size() > 0 && busy_q[0].lo <= cyc);
                chk("busy", busy, exp_busy);
                exp_ready = (exp_q.size() > 0 && exp_q[0].cyc <= cyc);
                chk("ready", memDataReady, exp_ready);
                if (exp_ready) begin
                    b = exp_q.pop_front();
                    if (memDataReady) begin
                        chk("index", memBlockIndex, b.idx);
                        chk("data", memDataIn, b.data);
                    end
                end
            end
        end
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        memReadRequest = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Expected beats from the line-fill rules: word address mod depth,
    // critical word first, wrap inside the line.
    task automatic push_line(input int c, input logic [31:0] addr);
        int a, base;
        beat_t b;
        win_t  w;
        a    = int'((addr >> 2) % MW);
        base = a - (a % BW);
        for (int k = 0; k < BW; k++) begin
            b.cyc  = c + FL + k;
            b.idx  = (a + k) % BW;
            b.data = model_mem[base + b.idx];
            exp_q.push_back(b);
        end
        w.lo = c;
        w.hi = c + FL + BW - 1;
        busy_q.push_back(w);
    endtask

    // Called at a falling edge with the controller idle at the next edge.
    task automatic full_req(input logic [31:0] addr);
        int c;
        c = cyc + 1;
        memReadRequest = 1'b1;
        memReadAddress = addr;
        push_line(c, addr);
        wait_until(c + FL);
        while (cyc < c + FL + BW) begin
            memReadRequest = 1'($urandom);
            memReadAddress = $urandom;
            @(negedge clk);
        end
        memReadRequest = 1'b0;
    endtask

    task automatic abort_req(input logic [31:0] addr, input int j);
        int   c;
        win_t w;
        c = cyc + 1;
        memReadRequest = 1'b1;
        memReadAddress = addr;
        w.lo = c;
        w.hi = c + j - 1;
        busy_q.push_back(w);
        wait_until(c + j - 1);
        memReadRequest = 1'b0;
        memReadAddress = $urandom;
        wait_until(c + j);
    endtask

    initial begin
        int c;
        logic [31:0] v;
        for (int i = 0; i < MW; i++) begin
            v = $urandom;
            model_mem[i] = v;
            dut.u_array.mem[i] = v;
        end
        for (int i = 0; i < 4; i++) begin
            v = 32'hA0 + i;
            model_mem[32'h40 + i] = v;
            dut.u_array.mem[32'h40 + i] = v;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(2);

        full_req(32'h0000_0100);
        idle(1);
        full_req(32'h0000_010C);
        idle(2);
        abort_req(32'h0000_0100, 3);
        idle(2);
        full_req(32'h0000_0100);
        full_req(32'h0000_0204);
        full_req(32'h0000_0108);
        idle(1);
        full_req(32'h4000_0104);
        abort_req(32'h0000_0300, FL);
        full_req(32'h0000_0304);
        idle(1);

        // Reset while beat 2 is on the outputs.
        c = cyc + 1;
        memReadRequest = 1'b1;
        memReadAddress = 32'h0000_0100;
        push_line(c, 32'h0000_0100);
        wait_until(c + FL);
        memReadRequest = 1'b0;
        wait_until(c + FL + 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        busy_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(4);
        full_req(32'h0000_0100);

        for (int t = 0; t < 40; t++) begin
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) abort_req($urandom, $urandom_range(1, FL));
            else full_req($urandom);
        end
        idle(4);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
